or_nbit_pipe: RTL and testbench

Parametrised, registered successor to the 1-bit OR testcase. Performs a selectable bitwise logic operation (OR/AND/XOR/NOR) on two WIDTH-bit operands, with an optional sticky-accumulate mode, behind valid/ready handshakes and a small output FIFO. It serves as an ArchBench testcase that exercises LUT logic, flops, and handshake paths through post-route simulation against a golden RTL model.

---
 rtl/or_nbit_pkg.sv | 25 ++
 rtl/or_nbit_fifo.sv | 59 +++++
 rtl/or_nbit_pipe.sv | 74 +++++++
 tb/tb_or_nbit_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/or_nbit_pkg.sv
// Shared types and the per-bit logic operation used by the or_nbit pipeline.
package or_nbit_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  // Single-bit operation; callers apply it across the operand width.
  function automatic logic apply_op(op_e op, logic a, logic b);
    logic res;
    res = 1'b0;
    case (op)
      OP_OR:   res = a | b;
      OP_AND:  res = a & b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/or_nbit_fifo.sv
// Circular synchronous FIFO; when empty the output holds the last popped word.
module or_nbit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] hold;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      hold   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        hold   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? hold : mem[rd_ptr];

endmodule

// File: rtl/or_nbit_pipe.sv
// Selectable bitwise logic op with sticky accumulator, feeding a small output FIFO.
module or_nbit_pipe
  import or_nbit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_a,
  input  logic [WIDTH-1:0]             in_b,
  input  logic [1:0]                   in_op,
  input  logic                         in_acc,
  input  logic                         in_clr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_y,
  output logic                         out_any,
  output logic [$clog2(DEPTH+1)-1:0]   out_level
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] y;
  logic             fifo_full;
  logic             fifo_empty;
  logic             xfer_in;
  logic             xfer_out;

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = out_valid && out_ready;

  always_comb begin
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      r[i] = apply_op(op_e'(in_op), in_a[i], in_b[i]);
    end
  end

  assign base = in_clr ? '0 : acc;
  assign y    = in_acc ? (r | base) : r;

  // Without in_acc the next acc equals base, which already folds in the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (xfer_in) begin
      acc <= in_acc ? y : base;
    end
  end

  or_nbit_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (xfer_in),
    .pop   (xfer_out),
    .wdata (y),
    .rdata (out_y),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (out_level)
  );

  assign out_any = |out_y;

endmodule

// File: tb/tb_or_nbit_pipe.sv
// Directed and random stimulus for or_nbit_pipe against a queue-based reference model.
module tb_or_nbit_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_acc;
  logic             in_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_any;
  logic [LW-1:0]    out_level;

  int n_checks = 0;
  int n_fail   = 0;

  or_nbit_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_acc    (in_acc),
    .in_clr    (in_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_any   (out_any),
    .out_level (out_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: queue of pending results, accumulator, last popped word.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_acc  = '0;
  logic [WIDTH-1:0] m_last = '0;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] m_y;
  logic [WIDTH-1:0] m_head;
  bit               m_rdy;
  bit               m_vld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_acc  = '0;
      m_last = '0;
    end else begin
      m_rdy = (mq.size() < DEPTH);
      m_vld = (mq.size() > 0);
      if (m_vld && out_ready) m_last = mq.pop_front();
      if (in_valid && m_rdy) begin
        case (in_op)
          2'd0:    m_r = in_a | in_b;
          2'd1:    m_r = in_a & in_b;
          2'd2:    m_r = in_a ^ in_b;
          default: m_r = ~(in_a | in_b);
        endcase
        m_y = in_acc ? (m_r | (in_clr ? '0 : m_acc)) : m_r;
        mq.push_back(m_y);
        if (in_acc)      m_acc = m_y;
        else if (in_clr) m_acc = '0;
      end
    end
  end

  always @(negedge clk) begin
    m_head = (mq.size() > 0) ? mq[0] : m_last;
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("out_y",     32'(out_y),     32'(m_head));
    chk("out_any",   32'(out_any),   32'(m_head != '0));
    chk("out_level", 32'(out_level), 32'(mq.size()));
    chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
  end

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op, input logic acc, input logic clr,
                       input logic ordy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    in_acc    = acc;
    in_clr    = clr;
    out_ready = ordy;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = 2'd0;
    in_acc    = 1'b0;
    in_clr    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y",     32'(out_y),     32'h00);
    chk("rst_out_level", 32'(out_level), 32'd0);

    // All four ops on A5/0F with the consumer always ready
    drive(1, 8'hA5, 8'h0F, 2'd0, 0, 0, 1);
    chk("op_or",  32'(out_y), 32'hAF);
    chk("op_or_valid", 32'(out_valid), 32'd1);
    drive(1, 8'hA5, 8'h0F, 2'd1, 0, 0, 1);
    chk("op_and", 32'(out_y), 32'h05);
    drive(1, 8'hA5, 8'h0F, 2'd2, 0, 0, 1);
    chk("op_xor", 32'(out_y), 32'hAA);
    drive(1, 8'hA5, 8'h0F, 2'd3, 0, 0, 1);
    chk("op_nor", 32'(out_y), 32'h50);
    chk("op_level", 32'(out_level), 32'd1);
    drive(0, 8'h00, 8'h00, 2'd0, 0, 0, 1);
    chk("empty_hold_y",  32'(out_y),     32'h50);
    chk("empty_valid",   32'(out_valid), 32'd0);

    // Accumulator chain
    drive(1, 8'h01, 8'h00, 2'd0, 1, 1, 1);
    chk("acc_1", 32'(out_y), 32'h01);
    drive(1, 8'h00, 8'h04, 2'd0, 1, 0, 1);
    chk("acc_2", 32'(out_y), 32'h05);
    drive(1, 8'h80, 8'h00, 2'd0, 1, 0, 1);
    chk("acc_3", 32'(out_y), 32'h85);
    chk("acc_any", 32'(out_any), 32'd1);
    drive(0, 8'h00, 8'h00, 2'd0, 0, 0, 1);

    // Backpressure into a DEPTH=2 FIFO
    drive(1, 8'h11, 8'h00, 2'd0, 0, 0, 0);
    chk("bp_lvl1",   32'(out_level), 32'd1);
    chk("bp_rdy1",   32'(in_ready),  32'd1);
    drive(1, 8'h22, 8'h00, 2'd0, 0, 0, 0);
    chk("bp_lvl2",   32'(out_level), 32'd2);
    chk("bp_rdy2",   32'(in_ready),  32'd0);
    drive(1, 8'h33, 8'h00, 2'd0, 0, 0, 0);
    chk("bp_held_lvl", 32'(out_level), 32'd2);
    chk("bp_held_y",   32'(out_y),     32'h11);
    drive(1, 8'h33, 8'h00, 2'd0, 0, 0, 1);
    chk("bp_pop_lvl", 32'(out_level), 32'd1);
    chk("bp_pop_y",   32'(out_y),     32'h22);
    drive(1, 8'h33, 8'h00, 2'd0, 0, 0, 0);
    chk("bp_push_lvl", 32'(out_level), 32'd2);
    drive(0, 8'h00, 8'h00, 2'd0, 0, 0, 1);
    chk("bp_order_3", 32'(out_y), 32'h33);
    drive(0, 8'h00, 8'h00, 2'd0, 0, 0, 1);
    chk("bp_drained", 32'(out_level), 32'd0);

    // Simultaneous push and pop at level 1
    drive(1, 8'h40, 8'h00, 2'd0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 8'h41 + 8'(i), 8'h00, 2'd0, 0, 0, 1);
      chk("pp_level", 32'(out_level), 32'd1);
      chk("pp_y",     32'(out_y),     32'(8'h41 + 8'(i)));
    end
    drive(0, 8'h00, 8'h00, 2'd0, 0, 0, 1);

    // Asynchronous reset mid-stream with a full FIFO and acc = FF
    drive(1, 8'hFF, 8'h00, 2'd0, 1, 1, 0);
    drive(1, 8'h00, 8'h00, 2'd0, 1, 0, 0);
    chk("pre_rst_lvl", 32'(out_level), 32'd2);
    chk("pre_rst_y",   32'(out_y),     32'hFF);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_y",     32'(out_y),     32'h00);
    chk("arst_out_any",   32'(out_any),   32'd0);
    chk("arst_out_level", 32'(out_level), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive(1, 8'h01, 8'h00, 2'd0, 1, 0, 1);
    chk("post_rst_acc", 32'(out_y), 32'h01);
    drive(0, 8'h00, 8'h00, 2'd0, 0, 0, 1);

    // Random traffic checked by the model on every cycle
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
            2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
